recon_reader: RTL and testbench

- Consumer end of the decoder output interface. Accepts one frame of nine 20-bit sigmoid outputs plus the original 9-bit input pixel vector through a valid/ready handshake.
- Streams the nine values out one per beat under backpressure. Thresholds each value into a reconstructed pixel bit.
- Reports the reconstructed 9-bit pattern, a mismatch count against the original pixels, and a match flag.
- Sits after the decoder sigmoid outputs. Feeds a UART/LED/host reader.

---
 rtl/recon_pkg.sv | 20 ++
 rtl/recon_thresh.sv | 17 +
 rtl/recon_reader.sv | 124 ++++++++++++
 tb/tb_recon_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/recon_pkg.sv
// Shared constants and types for the decoder-output reconstruction reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package recon_pkg;

    localparam int N_PIX     = 9;
    localparam int W         = 20;
    localparam int FRAC_BITS = 16;

    // Q3.16 constants: 1.0 and the 0.5 pixel-on threshold.
    localparam logic signed [W-1:0] ONE  = 20'sh10000;
    localparam logic signed [W-1:0] HALF = 20'sh08000;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_e;

endpackage

// File: rtl/recon_thresh.sv
// Signed threshold comparator: bit_o = (value_i >= thresh_i).
// Latency: combinational.
// Backpressure: none.
// Ports: value_i/thresh_i signed W-bit operands, bit_o result bit.
module recon_thresh #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] value_i,
    input  logic signed [W-1:0] thresh_i,
    output logic                bit_o
);

    // Both operands are declared signed, so negative values fall below any
    // non-negative threshold and values above 1.0 compare as plain integers.
    assign bit_o = (value_i >= thresh_i);

endmodule

// File: rtl/recon_reader.sv
// Captures one frame of nine sigmoid outputs plus the original pixels,
// streams the values one per beat, thresholds them into a reconstructed
// pattern and reports mismatch count and match flag.
// Latency: capture edge, 9 beats (s_ready high), done pulse, idle again; 11 cycles/frame.
// Backpressure: s_ready low holds the current beat stable; in_ready is low outside IDLE.
// Ports: clk/rst; in_valid/in_ready/y_in/x_ref frame input; s_* beat stream;
//        done_valid/recon/err_count/match frame result.
module recon_reader
    import recon_pkg::*;
#(
    parameter logic signed [W-1:0] THRESH = HALF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_PIX*W-1:0]    y_in,
    input  logic [N_PIX-1:0]      x_ref,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic signed [W-1:0]   s_data,
    output logic [3:0]            s_index,
    output logic                  s_bit,
    output logic                  s_last,
    output logic                  done_valid,
    output logic [N_PIX-1:0]      recon,
    output logic [3:0]            err_count,
    output logic                  match
);

    state_e                state_q;
    logic [3:0]            idx_q;
    logic signed [W-1:0]   y_q [N_PIX];
    logic [N_PIX-1:0]      x_q;
    logic [N_PIX-1:0]      work_recon_q;
    logic [3:0]            work_err_q;
    logic [N_PIX-1:0]      recon_q;
    logic [3:0]            err_q;
    logic                  match_q;

    logic [N_PIX-1:0]      work_recon_d;
    logic [3:0]            work_err_d;
    logic                  beat_acc;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign s_valid    = (state_q == STREAM) && !rst;
    assign s_data     = y_q[idx_q];
    assign s_index    = idx_q;
    assign s_last     = (idx_q == 4'(N_PIX - 1));
    assign done_valid = (state_q == DONE);
    assign recon      = recon_q;
    assign err_count  = err_q;
    assign match      = match_q;

    assign beat_acc   = s_valid && s_ready;

    recon_thresh #(
        .W (W)
    ) u_thresh (
        .value_i  (s_data),
        .thresh_i (THRESH),
        .bit_o    (s_bit)
    );

    // Working values after folding in the current beat.
    always_comb begin
        work_recon_d        = work_recon_q;
        work_recon_d[idx_q] = s_bit;
        work_err_d          = work_err_q + {3'b000, s_bit ^ x_q[idx_q]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_q          <= '0;
            work_recon_q <= '0;
            work_err_q   <= '0;
            recon_q      <= '0;
            err_q        <= '0;
            match_q      <= 1'b0;
            for (int i = 0; i < N_PIX; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_PIX; i++) begin
                            y_q[i] <= y_in[W*i +: W];
                        end
                        x_q          <= x_ref;
                        work_recon_q <= '0;
                        work_err_q   <= '0;
                        idx_q        <= '0;
                        state_q      <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_acc) begin
                        work_recon_q <= work_recon_d;
                        work_err_q   <= work_err_d;
                        if (s_last) begin
                            // Publish on the last beat so the results are
                            // already stable during the DONE pulse.
                            recon_q <= work_recon_d;
                            err_q   <= work_err_d;
                            match_q <= (work_err_d == 4'd0);
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recon_reader.sv
module tb_recon_reader;

    typedef logic signed [19:0] frame_t [9];

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [179:0]      y_in;
    logic [8:0]        x_ref;
    logic              s_valid;
    logic              s_ready;
    logic signed [19:0] s_data;
    logic [3:0]        s_index;
    logic              s_bit;
    logic              s_last;
    logic              done_valid;
    logic [8:0]        recon;
    logic [3:0]        err_count;
    logic              match;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    recon_reader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y_in       (y_in),
        .x_ref      (x_ref),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_index    (s_index),
        .s_bit      (s_bit),
        .s_last     (s_last),
        .done_valid (done_valid),
        .recon      (recon),
        .err_count  (err_count),
        .match      (match)
    );

    // Reference rule: a pixel is on when its value is at least 0.5 (0x08000),
    // compared as signed integers.
    function automatic logic ref_bit(input logic signed [19:0] v);
        int iv;
        iv = int'(v);
        return (iv >= 32'sh8000);
    endfunction

    function automatic logic [179:0] pack_frame(input frame_t f);
        logic [179:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[20*i +: 20] = f[i];
        return p;
    endfunction

    // Presents one frame, streams it under the given s_ready pattern
    // (0: always ready, 1: alternating starting with 0, 2: random) and checks
    // every beat and the result. With hold=1, in_valid stays high and y_in is
    // scrambled during the frame. Returns at the cycle after DONE.
    task automatic run_frame(input frame_t f, input logic [8:0] x, input int mode,
                             input bit hold, input int exp_done);
        logic [8:0] exp_recon;
        int         exp_err;
        int         k;
        int         cyc;
        logic       rdy;
        exp_recon = '0;
        for (int i = 0; i < 9; i++) exp_recon[i] = ref_bit(f[i]);
        exp_err = $countones(exp_recon ^ x);

        in_valid = 1'b1;
        y_in     = pack_frame(f);
        x_ref    = x;
        s_ready  = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL cap_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        k = 0;
        cyc = 1;
        while (k < 9 && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            s_ready = rdy;
            if (hold) y_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            n_checks++;
            if (s_valid !== 1'b1 || s_index !== 4'(k) || s_data !== f[k] ||
                s_bit !== ref_bit(f[k]) || s_last !== (k == 8))
                $display("FAIL beat%0d got v=%b idx=%0d d=%h bit=%b last=%b exp v=1 idx=%0d d=%h bit=%b last=%b",
                         k, s_valid, s_index, s_data, s_bit, s_last, k, f[k], ref_bit(f[k]), k == 8);
            else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0 || done_valid !== 1'b0)
                $display("FAIL stream_flags got rdy=%b done=%b exp 0 0", in_ready, done_valid);
            else n_pass++;
            @(posedge clk); #1;
            if (rdy) k++;
            cyc++;
        end
        n_checks++;
        if (k != 9) $display("FAIL stream_timeout got beats=%0d exp=9", k);
        else n_pass++;
        s_ready = 1'b0;
        #1;
        n_checks++;
        if (done_valid !== 1'b1 || s_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL done_pulse got done=%b sv=%b rdy=%b exp 1 0 0", done_valid, s_valid, in_ready);
        else n_pass++;
        n_checks++;
        if (recon !== exp_recon || err_count !== 4'(exp_err) || match !== (exp_err == 0))
            $display("FAIL result got recon=%h err=%0d match=%b exp recon=%h err=%0d match=%b",
                     recon, err_count, match, exp_recon, exp_err, exp_err == 0);
        else n_pass++;
        if (exp_done >= 0) begin
            n_checks++;
            if (cyc != exp_done) $display("FAIL done_cycle got=%0d exp=%0d", cyc, exp_done);
            else n_pass++;
        end
        @(posedge clk); #1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || done_valid !== 1'b0 || recon !== exp_recon ||
            err_count !== 4'(exp_err))
            $display("FAIL after_done got rdy=%b done=%b recon=%h err=%0d exp 1 0 %h %0d",
                     in_ready, done_valid, recon, err_count, exp_recon, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; s_ready = 1'b0; y_in = '0; x_ref = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || s_valid !== 1'b0)
            $display("FAIL in_reset got rdy=%b sv=%b exp 0 0", in_ready, s_valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || s_valid !== 1'b0 || done_valid !== 1'b0 ||
            recon !== 9'h0 || err_count !== 4'h0 || match !== 1'b0)
            $display("FAIL reset_vals got rdy=%b sv=%b dv=%b recon=%h err=%0d m=%b exp 1 0 0 0 0 0",
                     in_ready, s_valid, done_valid, recon, err_count, match);
        else n_pass++;
    endtask

    task automatic test_all_ones();
        frame_t f;
        for (int i = 0; i < 9; i++) f[i] = 20'sh10000;
        run_frame(f, 9'h1FF, 0, 1'b0, 10);
    endtask

    task automatic test_threshold();
        frame_t f;
        for (int i = 0; i < 9; i++) f[i] = '0;
        f[0] = 20'sh08000; f[1] = 20'sh07FFF; f[2] = 20'shFFFFF; f[3] = 20'sh7FFFF;
        run_frame(f, 9'h000, 0, 1'b0, 10);
    endtask

    task automatic test_backpressure();
        frame_t f;
        for (int i = 0; i < 9; i++) f[i] = 20'sh10000;
        run_frame(f, 9'h1FF, 1, 1'b0, 19);
    endtask

    task automatic test_back_to_back();
        frame_t a;
        frame_t b;
        for (int i = 0; i < 9; i++) begin
            a[i] = 20'($urandom);
            b[i] = 20'sh08000 + 20'($urandom_range(0, 4)) - 20'sd2;
        end
        run_frame(a, 9'($urandom), 0, 1'b1, 10);
        // Second capture lands at cycle 11 of the first frame.
        run_frame(b, 9'($urandom), 0, 1'b0, 10);
    endtask

    task automatic test_max_err();
        frame_t f;
        for (int i = 0; i < 9; i++) f[i] = (i % 2 == 1) ? 20'sh10000 : 20'sh00000;
        run_frame(f, 9'h155, 0, 1'b0, 10);
    endtask

    task automatic test_random();
        frame_t f;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 9; i++)
                f[i] = ($urandom_range(0, 1) == 1) ? 20'($urandom)
                                                   : 20'sh08000 + 20'($urandom_range(0, 2)) - 20'sd1;
            run_frame(f, 9'($urandom), 2, 1'b0, -1);
        end
    endtask

    task automatic test_reset_abort();
        frame_t f;
        int     beats;
        for (int i = 0; i < 9; i++) f[i] = 20'sh10000;
        in_valid = 1'b1; y_in = pack_frame(f); x_ref = 9'h000; s_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (s_valid === 1'b1) beats++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (beats != 5) $display("FAIL abort_beats got=%0d exp=5", beats);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (s_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL abort_in_rst got sv=%b rdy=%b exp 0 0", s_valid, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_valid !== 1'b0 || done_valid !== 1'b0 || recon !== 9'h0 ||
            err_count !== 4'h0 || match !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL abort_after got sv=%b dv=%b recon=%h err=%0d m=%b rdy=%b exp 0 0 0 0 0 1",
                     s_valid, done_valid, recon, err_count, match, in_ready);
        else n_pass++;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done_valid !== 1'b0 || s_valid !== 1'b0)
                $display("FAIL abort_quiet got dv=%b sv=%b exp 0 0", done_valid, s_valid);
            else n_pass++;
        end
        for (int i = 0; i < 9; i++) f[i] = (i < 4) ? 20'sh0C000 : -20'sh00100;
        run_frame(f, 9'h00F, 0, 1'b0, 10);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_threshold();
        test_backpressure();
        test_back_to_back();
        test_max_err();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
